// File: rtl/bcd_timer_counter.sv
// bcd_timer_counter: two-digit BCD up-counter (00-99 or 00-59) stepped by a prescaler,
// with run/pause/done control and a one-cycle Done pulse at the terminal count.
module bcd_timer_counter #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic       ModeSel,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  output logic [7:0] CountOut,
  output logic       Running,
  output logic       Done,
  output logic       ModeLatched
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [1:0]    r_state, w_state_nx;
  logic [PW-1:0] r_presc, w_presc_nx;
  logic [7:0]    r_count, w_count_nx, w_count_inc;
  logic          r_mode, w_mode_nx;
  logic          r_running, r_done, w_done_nx;
  logic          w_wrap, w_term;
  // Tens never overflow: the latched mode stops counting at 59 or 99.
  assign w_count_inc = (r_count[3:0] == 4'd9) ? {r_count[7:4] + 4'd1, 4'd0}
                                              : {r_count[7:4], r_count[3:0] + 4'd1};
  assign w_wrap = r_presc == PW'(TICK_DIV - 1);
  assign w_term = w_count_inc == (r_mode ? 8'h59 : 8'h99);
  always_comb begin
    w_state_nx = r_state;
    w_presc_nx = r_presc;
    w_count_nx = r_count;
    w_mode_nx  = r_mode;
    w_done_nx  = 1'b0;
    if (Clear) begin
      w_state_nx = S_IDLE;
      w_presc_nx = '0;
      w_count_nx = 8'h00;
    end else if (Stop) begin
      w_state_nx = (r_state == S_RUN) ? S_PAUSE : r_state;
    end else if (Start && (r_state == S_IDLE || r_state == S_DONE)) begin
      w_state_nx = S_RUN;
      w_mode_nx  = ModeSel;
      w_presc_nx = '0;
      w_count_nx = 8'h00;
    end else if (Start && r_state == S_PAUSE) begin
      w_state_nx = S_RUN;
    end else if (r_state == S_RUN) begin
      w_presc_nx = w_wrap ? '0 : r_presc + PW'(1);
      w_count_nx = w_wrap ? w_count_inc : r_count;
      w_done_nx  = w_wrap && w_term;
      w_state_nx = (w_wrap && w_term) ? S_DONE : S_RUN;
    end
  end
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_count   <= 8'h00;
      r_mode    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_presc   <= w_presc_nx;
      r_count   <= w_count_nx;
      r_mode    <= w_mode_nx;
      r_running <= w_state_nx == S_RUN;
      r_done    <= w_done_nx;
    end
  end
  assign CountOut    = r_count;
  assign Running     = r_running;
  assign Done        = r_done;
  assign ModeLatched = r_mode;
endmodule

// File: tb/tb_bcd_timer_counter.sv
// tb_bcd_timer_counter: directed scenarios plus random control traffic, checked each cycle
// against a decimal-valued behavioural model of the timer.
module tb_bcd_timer_counter;
  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic       Clk = 1'b0, Resetn = 1'b0, ModeSel = 1'b0, Start = 1'b0, Stop = 1'b0, Clear = 1'b0;
  logic [7:0] CountOut;
  logic       Running, Done, ModeLatched;
  int n_chk = 0, n_pass = 0;
  int m_st, m_v, m_p, m_mode, m_done;
  int dones, first, n;
  bcd_timer_counter #(.TICK_DIV(TD)) dut (
    .Clk(Clk), .Resetn(Resetn), .ModeSel(ModeSel), .Start(Start), .Stop(Stop), .Clear(Clear),
    .CountOut(CountOut), .Running(Running), .Done(Done), .ModeLatched(ModeLatched)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  function automatic int bcd(input int v);
    return (v / 10) * 16 + v % 10;
  endfunction
  task automatic m_reset();
    m_st = M_IDLE; m_v = 0; m_p = 0; m_mode = 0; m_done = 0;
  endtask
  // Count is held as a plain decimal number; a step happens after TD advancing RUN cycles.
  task automatic m_edge(input bit sta, input bit stp, input bit clr, input bit ms);
    m_done = 0;
    if (!Resetn) m_reset();
    else if (clr) begin m_st = M_IDLE; m_v = 0; m_p = 0; end
    else if (stp) begin if (m_st == M_RUN) m_st = M_PAUSE; end
    else if (sta && (m_st == M_IDLE || m_st == M_DONE)) begin m_st = M_RUN; m_mode = ms; m_v = 0; m_p = 0; end
    else if (sta && m_st == M_PAUSE) m_st = M_RUN;
    else if (m_st == M_RUN) begin
      m_p++;
      if (m_p == TD) begin
        m_p = 0; m_v++;
        if (m_v == (m_mode ? 59 : 99)) begin m_st = M_DONE; m_done = 1; end
      end
    end
  endtask
  task automatic cmp(input string tag);
    chk({tag, ".count"}, CountOut, bcd(m_v));
    chk({tag, ".running"}, Running, m_st == M_RUN);
    chk({tag, ".done"}, Done, m_done);
    chk({tag, ".mode"}, ModeLatched, m_mode);
    chk({tag, ".bcd_ok"}, CountOut[3:0] <= 4'd9 && CountOut[7:4] <= 4'd9, 1);
  endtask
  task automatic cyc(input bit sta, input bit stp, input bit clr, input bit ms, input string tag);
    Start = sta; Stop = stp; Clear = clr; ModeSel = ms;
    @(posedge Clk);
    m_edge(sta, stp, clr, ms);
    #1 cmp(tag);
  endtask
  task automatic run_until(input int v, input int p, input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (m_st == M_RUN && m_v == v && m_p == p) return;
      cyc(0, 0, 0, 1'($urandom_range(0, 1)), tag);
    end
    chk({tag, ".timeout"}, 0, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    m_reset();
    repeat (3) cyc(0, 0, 0, 0, "rst");
    chk("rst.count0", CountOut, 8'h00);
    Resetn = 1'b1;
    repeat (5) cyc(0, 1, 0, 1'($urandom_range(0, 1)), "idle");
    chk("idle.no_run", Running, 0);
    // Mode A full run
    cyc(1, 0, 0, 0, "a.start");
    dones = 0; first = 0;
    for (int i = 1; i <= 500 && m_st != M_DONE; i++) begin
      cyc(0, 0, 0, 1'($urandom_range(0, 1)), "a.run");
      dones += int'(Done);
      if (first == 0 && CountOut == 8'h01) first = i;
    end
    repeat (5) begin cyc(0, 1, 0, 0, "a.hold"); dones += int'(Done); end
    chk("a.first_step", first, TD);
    chk("a.done_pulses", dones, 1);
    chk("a.final", CountOut, 8'h99);
    // Mode B, started from DONE, ModeSel toggling mid-run
    cyc(1, 0, 0, 1, "b.start");
    chk("b.restart_zero", CountOut, 8'h00);
    n = 0; dones = 0;
    for (int i = 1; i <= 400; i++) begin
      cyc(0, 0, 0, 1'($urandom_range(0, 1)), "b.run");
      if (Done) begin n = i; break; end
    end
    chk("b.cycles", n, 236);
    chk("b.final", CountOut, 8'h59);
    chk("b.mode", ModeLatched, 1);
    repeat (3) begin cyc(0, 0, 0, 0, "b.hold"); dones += int'(Done); end
    chk("b.no_extra_done", dones, 0);
    // Restart from DONE back into Mode A
    cyc(1, 0, 0, 0, "r.start");
    chk("r.zero", CountOut, 8'h00);
    chk("r.mode", ModeLatched, 0);
    for (int i = 0; i < 500 && !Done; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)), "r.run");
    chk("r.final", CountOut, 8'h99);
    // Pause at 23 with the prescaler two counts in
    cyc(0, 0, 1, 0, "p.clr");
    cyc(1, 0, 0, 0, "p.start");
    run_until(23, 2, "p.wait");
    cyc(0, 1, 0, 0, "p.stop");
    repeat (10) cyc(0, 0, 0, 1'($urandom_range(0, 1)), "p.hold");
    chk("p.frozen", CountOut, 8'h23);
    cyc(1, 0, 0, 0, "p.resume");
    chk("p.resume_val", CountOut, 8'h23);
    cyc(0, 0, 0, 0, "p.r1");
    chk("p.after1", CountOut, 8'h23);
    cyc(0, 0, 0, 0, "p.r2");
    chk("p.after2", CountOut, 8'h24);
    // Priority: all three controls at 47, then Stop coincident with a step
    run_until(47, 1, "pri.wait");
    cyc(1, 1, 1, 0, "pri.all");
    chk("pri.count", CountOut, 8'h00);
    chk("pri.running", Running, 0);
    cyc(1, 0, 0, 0, "pri.start");
    run_until(9, TD - 1, "pri.wait9");
    cyc(0, 1, 0, 0, "pri.stop_step");
    chk("pri.held09", CountOut, 8'h09);
    repeat (3) cyc(0, 0, 0, 0, "pri.pause");
    cyc(1, 0, 0, 0, "pri.resume");
    chk("pri.resume09", CountOut, 8'h09);
    cyc(0, 0, 0, 0, "pri.step");
    chk("pri.ten", CountOut, 8'h10);
    // Asynchronous reset mid-count at 71
    cyc(0, 0, 1, 0, "rs.clr");
    cyc(1, 0, 0, 0, "rs.start");
    run_until(71, 1, "rs.wait");
    #2 Resetn = 1'b0;
    #1 m_reset();
    cmp("rs.async");
    chk("rs.async_count", CountOut, 8'h00);
    repeat (2) cyc(1, 0, 0, 1, "rs.low");
    Resetn = 1'b1;
    repeat (10) cyc(0, 0, 0, 1'($urandom_range(0, 1)), "rs.idle");
    chk("rs.no_count", CountOut, 8'h00);
    // Random control traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
          1'($urandom_range(0, 1)), "rnd");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bcd_timer_counter.md
BCD_TIMER_COUNTER -- requirements
Module: bcd_timer_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving Clk cycles per count step (minimum 2).
REQ-002 The block SHALL have input Clk, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have input Resetn, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have input ModeSel, 1 bit: 0 = Mode A (range 00-99), 1 = Mode B (range 00-59).
REQ-005 The block SHALL have input Start, 1 bit: level-sampled start/resume request.
REQ-006 The block SHALL have input Stop, 1 bit: level-sampled pause request.
REQ-007 The block SHALL have input Clear, 1 bit: level-sampled clear request.
REQ-008 The block SHALL have output CountOut, 8 bits: two BCD digits, tens in [7:4], ones in [3:0]; it feeds the downstream count-direction reverser unchanged.
REQ-009 The block SHALL have output Running, 1 bit: high in RUN only.
REQ-010 The block SHALL have output Done, 1 bit: one-cycle pulse when the terminal count is reached.
REQ-011 The block SHALL have output ModeLatched, 1 bit: the mode currently in force.

Function
REQ-012 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-013 Control priority each cycle SHALL be Clear > Stop > Start.
REQ-014 Clear in any state SHALL go to IDLE, set CountOut=8'h00 and zero the prescaler on the next edge.
REQ-015 IDLE + Start SHALL latch ModeSel into ModeLatched, go to RUN and start the prescaler at 0.
REQ-016 ModeSel changes outside IDLE, and outside Start-from-DONE, SHALL be ignored.
REQ-017 In RUN the prescaler SHALL count 0..TICK_DIV-1 and wrap; each wrap SHALL be a step, so the first step occurs TICK_DIV cycles after entering RUN.
REQ-018 A step SHALL increment CountOut in BCD: ones 9 -> 0 with carry into tens; no digit SHALL ever exceed 9.
REQ-019 The terminal count SHALL be 8'h99 in Mode A and 8'h59 in Mode B.
REQ-020 The step that reaches terminal SHALL go to DONE with Done high for exactly that following cycle; CountOut SHALL hold the terminal value.
REQ-021 RUN + Stop SHALL go to PAUSE, freezing CountOut and the prescaler.
REQ-022 PAUSE + Start SHALL return to RUN and resume from the frozen prescaler value (no lost or extra cycles).
REQ-023 DONE + Start SHALL re-latch ModeSel, set CountOut=8'h00, go to RUN and restart the prescaler at 0.
REQ-024 A step and a Stop in the same cycle: Stop wins; no increment; prescaler frozen at TICK_DIV-1 so the step occurs on the first RUN cycle after resume.
REQ-025 Stop in IDLE/DONE and Start in RUN SHALL have no effect.
REQ-026 Running SHALL be a registered decode of the state (high exactly while in RUN).

Reset
REQ-027 Resetn low SHALL immediately force IDLE, CountOut=8'h00, prescaler=0, Running=0, Done=0, ModeLatched=0, including mid-count.
REQ-028 After Resetn deasserts, the block SHALL remain in IDLE until Start is sampled high.

Verification (bench uses TICK_DIV=4)
REQ-029 Mode A: Start for 1 cycle -> CountOut steps 00,01..09,10..99 every 4 cycles with no non-BCD value; Done pulses once at 99; holds 99.
REQ-030 Mode B: ModeSel=1, Start -> reaches 59 after 236 cycles in RUN (59 steps x 4); Done pulses once; ModeSel toggled mid-run has no effect.
REQ-031 Pause: Stop at 23 two cycles after a step, hold 10 cycles, then Start -> 23 holds; next step to 24 exactly 2 RUN cycles after resume.
REQ-032 Priority: Clear+Stop+Start together at 47 -> IDLE, 00, Running=0; Stop coincident with the step from 09 -> stays 09; 10 appears on the first RUN cycle after Start.
REQ-033 Restart: in DONE at 59 (Mode B), ModeSel=0, Start -> 00, ModeLatched=0, counts to 99.
REQ-034 Reset: Resetn low asynchronously mid-count at 71 -> outputs reach reset values before the next Clk edge; no count until Start.
